// File: rtl/instr_dispatch.sv
// Instruction dispatcher: accepts one instruction at a time, decodes the
// opcode to a one-hot datapath FSM start, waits for that FSM's done pulse
// (with a cycle timeout), retires the instruction and counts retirements.
module instr_dispatch #(
  parameter int unsigned TIMEOUT_CYCLES = 32,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  input  logic [3:0]       fsm_done,
  input  logic             clear_error,
  output logic             instr_ready,
  output logic [3:0]       FSM_start,
  output logic [3:0]       opcode,
  output logic [5:0]       param1,
  output logic [5:0]       param2,
  output logic             busy,
  output logic             done_pulse,
  output logic             error,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DECODE   = 3'd1,
    START    = 3'd2,
    WAIT     = 3'd3,
    COMPLETE = 3'd4,
    ERROR    = 3'd5
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  state_t     next_state;
  logic [3:0] sel;
  logic [3:0] dec_sel;
  logic       decoded;
  logic [7:0] timer;
  logic       sel_done;

  assign sel_done = |(fsm_done & sel);

  // Opcode to one-hot FSM select; all-zero marks an illegal opcode.
  always_comb begin
    dec_sel = '0;
    if (!opcode[3]) begin
      dec_sel = 4'b0001;
    end else begin
      unique case (opcode[2:0])
        3'b000:  dec_sel = 4'b0010;
        3'b001:  dec_sel = 4'b0100;
        3'b010:  dec_sel = 4'b1000;
        default: dec_sel = '0;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic. DECODE lasts two cycles: the first registers the
  // one-hot select, the second branches on it, placing START at N+2.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (instr_valid) next_state = DECODE;
      DECODE:   if (decoded) next_state = (sel == '0) ? ERROR : START;
      START:    next_state = WAIT;
      WAIT: begin
        if (sel_done)                 next_state = COMPLETE;
        else if (timer == TIMER_LAST) next_state = ERROR;
      end
      COMPLETE: next_state = IDLE;
      ERROR:    if (clear_error) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Datapath registers: latched fields, select, WAIT timer, counter, timeout flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      opcode      <= '0;
      param1      <= '0;
      param2      <= '0;
      sel         <= '0;
      decoded     <= 1'b0;
      timer       <= '0;
      timeout     <= 1'b0;
      instr_count <= '0;
    end else begin
      if (state == IDLE && instr_valid) begin
        opcode  <= instr[15:12];
        param1  <= instr[11:6];
        param2  <= instr[5:0];
        decoded <= 1'b0;
      end
      if (state == DECODE && !decoded) begin
        sel     <= dec_sel;
        decoded <= 1'b1;
      end
      if (state == START) timer <= '0;
      if (state == WAIT)  timer <= timer + 8'd1;
      if (state == COMPLETE) instr_count <= instr_count + 1'b1;
      if (state == WAIT && next_state == ERROR)        timeout <= 1'b1;
      else if (state == DECODE && next_state == ERROR) timeout <= 1'b0;
      else if (state == ERROR && clear_error)          timeout <= 1'b0;
    end
  end

  assign instr_ready = (state == IDLE);
  assign busy        = (state == DECODE) || (state == START) ||
                       (state == WAIT)   || (state == COMPLETE);
  assign done_pulse  = (state == COMPLETE);
  assign error       = (state == ERROR);
  assign FSM_start   = (state == START) ? sel : '0;

endmodule

// File: tb/tb_instr_dispatch.sv
// Self-checking bench for instr_dispatch: table-driven instructions plus
// hand-written timeout, counter-wrap and mid-instruction reset sequences,
// with a scoreboard for FSM_start pulses and retirement counts.
module tb_instr_dispatch;

  localparam int unsigned TO = 32;
  localparam int unsigned CW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic [15:0]   instr;
  logic [3:0]    fsm_done;
  logic          clear_error;
  logic          instr_ready;
  logic [3:0]    FSM_start;
  logic [3:0]    opcode;
  logic [5:0]    param1;
  logic [5:0]    param2;
  logic          busy;
  logic          done_pulse;
  logic          error;
  logic          timeout;
  logic [CW-1:0] instr_count;

  instr_dispatch #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .fsm_done(fsm_done), .clear_error(clear_error), .instr_ready(instr_ready),
    .FSM_start(FSM_start), .opcode(opcode), .param1(param1), .param2(param2),
    .busy(busy), .done_pulse(done_pulse), .error(error), .timeout(timeout),
    .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [3:0]    start_q[$];
  logic [CW-1:0] cnt_q[$];
  logic [CW-1:0] exp_cnt = '0;
  logic          cnt_pend = 1'b0;

  typedef struct {
    logic [15:0] ins;
    logic [3:0]  sel;
    int          delay;
    bit          noise;
    bit          clr;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every FSM_start pulse and every retirement is matched
  // against what the stimulus side pushed.
  always @(negedge clock) begin
    if (cnt_pend) begin
      if (cnt_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_retire: count=%0h expected no retirement", instr_count);
      end else begin
        chk("sb_count", instr_count, cnt_q.pop_front());
      end
    end
    cnt_pend = done_pulse;
    if (FSM_start != 4'b0000) begin
      if (start_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL stray_start: got %b expected 0000", FSM_start);
      end else begin
        chk("sb_start", FSM_start, start_q.pop_front());
      end
    end
  end

  // Releases ERROR and checks the return to IDLE; entered at an ERROR negedge.
  task automatic clear_err(input logic [3:0] op);
    @(negedge clock);
    chk("error_hold", error, 1);
    chk("ready_err", instr_ready, 0);
    clear_error = 1'b1;
    @(negedge clock);
    clear_error = 1'b0;
    chk("error_clr", error, 0);
    chk("timeout_clr", timeout, 0);
    chk("ready_after_clr", instr_ready, 1);
    chk("opcode_held", opcode, op);
  endtask

  // Runs one instruction starting at an IDLE negedge; ends at an IDLE negedge.
  // delay: WAIT cycle on which the selected done arrives (0 = never).
  task automatic do_instr(input logic [15:0] ins, input logic [3:0] sel,
                          input int delay, input bit noise, input bit clr);
    chk("ready_idle", instr_ready, 1);
    instr       = ins;
    instr_valid = 1'b1;
    if (sel != 4'b0000) start_q.push_back(sel);
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    instr       = 16'($urandom);
    if (noise) fsm_done = (sel == 4'b0000) ? 4'hF : sel;
    @(negedge clock);
    chk("busy_decode", busy, 1);
    chk("ready_decode", instr_ready, 0);
    chk("opcode", opcode, ins[15:12]);
    chk("param1", param1, ins[11:6]);
    chk("param2", param2, ins[5:0]);
    chk("start_n0", FSM_start, 0);
    @(negedge clock);
    chk("start_n1", FSM_start, 0);
    fsm_done = 4'b0000;
    @(negedge clock);
    if (sel == 4'b0000) begin
      chk("illegal_error", error, 1);
      chk("illegal_timeout", timeout, 0);
      chk("illegal_busy", busy, 0);
      chk("illegal_start", FSM_start, 0);
      clear_err(ins[15:12]);
    end else begin
      chk("start_latency", FSM_start, sel);
      chk("busy_start", busy, 1);
      clear_error = clr;
      if (delay == 0) begin
        for (int k = 0; k < int'(TO); k++) begin
          @(negedge clock);
          fsm_done = k[0] ? 4'b0100 : 4'b0000;
          chk("busy_wait", busy, 1);
          chk("error_wait", error, 0);
        end
        @(negedge clock);
        fsm_done = 4'b0000;
        chk("to_error", error, 1);
        chk("to_timeout", timeout, 1);
        chk("to_busy", busy, 0);
        clear_err(ins[15:12]);
      end else begin
        for (int k = 1; k < delay; k++) begin
          @(negedge clock);
          fsm_done = noise ? ~sel : 4'b0000;
          chk("busy_wait", busy, 1);
          chk("start_wait", FSM_start, 0);
        end
        @(negedge clock);
        fsm_done    = sel;
        clear_error = 1'b0;
        exp_cnt     = exp_cnt + 1'b1;
        cnt_q.push_back(exp_cnt);
        chk("error_wait", error, 0);
        @(negedge clock);
        fsm_done = 4'b0000;
        chk("done_pulse", done_pulse, 1);
        chk("error_complete", error, 0);
        chk("busy_complete", busy, 1);
        @(negedge clock);
        chk("done_single", done_pulse, 0);
        chk("ready_back", instr_ready, 1);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h30C5, 4'b0001, 13, 1'b0, 1'b0};
    vecs[1] = '{16'h0FFF, 4'b0001,  1, 1'b1, 1'b0};
    vecs[2] = '{16'h7A3C, 4'b0001,  5, 1'b0, 1'b1};
    vecs[3] = '{16'h8041, 4'b0010,  1, 1'b0, 1'b0};
    vecs[4] = '{16'h9082, 4'b0100,  1, 1'b1, 1'b0};
    vecs[5] = '{16'hA0C3, 4'b1000,  1, 1'b0, 1'b0};
    vecs[6] = '{16'hB000, 4'b0000,  0, 1'b1, 1'b0};
    vecs[7] = '{16'hC5A5, 4'b0000,  0, 1'b0, 1'b0};
    vecs[8] = '{16'hFFFF, 4'b0000,  0, 1'b0, 1'b0};
    vecs[9] = '{16'h5555, 4'b0001, 32, 1'b1, 1'b0};

    reset       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    fsm_done    = '0;
    clear_error = 1'b0;
    #12;
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_start", FSM_start, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_error", error, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_opcode", opcode, 0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 10; i++)
      do_instr(vecs[i].ins, vecs[i].sel, vecs[i].delay, vecs[i].noise, vecs[i].clr);

    do_instr(16'h0123, 4'b0001, 0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++)
      do_instr(16'h4321, 4'b0001, 1, 1'b0, 1'b0);
    chk("count_after_wrap", instr_count, exp_cnt);

    // Abandon an instruction in WAIT with an asynchronous reset.
    instr       = 16'h2001;
    instr_valid = 1'b1;
    start_q.push_back(4'b0001);
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    repeat (5) @(negedge clock);
    chk("busy_pre_reset", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_ready", instr_ready, 1);
    chk("ar_busy", busy, 0);
    chk("ar_count", instr_count, 0);
    chk("ar_start", FSM_start, 0);
    chk("ar_done", done_pulse, 0);
    chk("ar_opcode", opcode, 0);
    chk("ar_param1", param1, 0);
    chk("ar_param2", param2, 0);
    chk("ar_error", error, 0);
    exp_cnt = '0;
    @(negedge clock);
    reset = 1'b1;
    do_instr(16'h9ABC, 4'b0100, 2, 1'b0, 1'b0);

    repeat (2) @(negedge clock);
    chk("start_q_empty", start_q.size(), 0);
    chk("cnt_q_empty", cnt_q.size(), 0);
    chk("final_count", instr_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_dispatch.md
INSTR_DISPATCH -- requirements
Module: instr_dispatch

Interface
- REQ-001: Parameter TIMEOUT_CYCLES, default 32, WAIT-state cycle limit before the timeout error (legal range 2..255).
- REQ-002: Parameter CNT_W, default 16, width of the retired-instruction counter.
- REQ-003: clock  input  1  single clock; all state updates on its rising edge.
- REQ-004: reset  input  1  asynchronous, active-low reset.
- REQ-005: instr_valid  input  1  upstream instruction present.
- REQ-006: instr  input  16  instruction word: [15:12] opcode, [11:6] param1, [5:0] param2.
- REQ-007: fsm_done  input  4  per-FSM done pulses; bit0 ALU, bit1 load-immediate, bit2 move, bit3 output/store.
- REQ-008: clear_error  input  1  releases the ERROR state.
- REQ-009: instr_ready  output  1  dispatcher can accept an instruction.
- REQ-010: FSM_start  output  4  one-hot start to the selected datapath FSM.
- REQ-011: opcode / param1 / param2  output  4 / 6 / 6  latched fields driven to all FSMs.
- REQ-012: busy  output  1  an instruction is in flight.
- REQ-013: done_pulse  output  1  one-cycle retire strobe.
- REQ-014: error  output  1  sticky fault flag.
- REQ-015: timeout  output  1  sticky; set when the fault cause is timeout, clear for an illegal opcode.
- REQ-016: instr_count  output  CNT_W  count of retired instructions.

Function
- REQ-017: States SHALL be IDLE, DECODE, START, WAIT, COMPLETE, ERROR, binary encoded.
- REQ-018: instr_ready SHALL be 1 only in IDLE; a handshake is instr_valid && instr_ready at a rising edge.
- REQ-019: On handshake, instr fields SHALL latch into opcode/param1/param2 and the state SHALL go to DECODE; latched fields SHALL hold until the next handshake.
- REQ-020: DECODE SHALL map opcodes as follows: 0000-0111 -> bit0; 1000 -> bit1; 1001 -> bit2; 1010 -> bit3; 1011-1111 -> illegal, which goes to ERROR with timeout=0.
- REQ-021: START SHALL assert exactly one FSM_start bit for exactly one cycle, clear the WAIT timer, and go to WAIT.
- REQ-022: Latency: for a handshake at edge N, FSM_start is high from edge N+2 to edge N+3.
- REQ-023: FSM_start SHALL be 4'b0000 in every state other than START; at most one bit is ever set.
- REQ-024: WAIT SHALL increment the timer each cycle; fsm_done at the selected bit goes to COMPLETE.
- REQ-025: In WAIT, if the timer reaches TIMEOUT_CYCLES-1 without the selected done, the next state SHALL be ERROR with timeout=1.
- REQ-026: If the selected done and the timeout occur in the same cycle, done SHALL win.
- REQ-027: fsm_done bits other than the selected bit SHALL be ignored in all states; any fsm_done outside WAIT SHALL be ignored.
- REQ-028: COMPLETE SHALL assert done_pulse for one cycle, increment instr_count (wrapping from all-ones to 0), and return to IDLE.
- REQ-029: busy SHALL be 1 in DECODE, START, WAIT and COMPLETE, and 0 in IDLE and ERROR.
- REQ-030: ERROR SHALL hold error=1 and instr_ready=0 until a cycle with clear_error=1, then go to IDLE and clear error and timeout on that edge.
- REQ-031: clear_error in any state other than ERROR SHALL have no effect.
- REQ-032: Minimum back-to-back spacing: the IDLE after COMPLETE can accept on its first cycle.

Reset
- REQ-033: reset=0 SHALL immediately (asynchronously) force state IDLE.
- REQ-034: While reset=0, all outputs SHALL be 0 except instr_ready, which SHALL be 1; this includes FSM_start=0000, instr_count=0 and the latched fields=0.
- REQ-035: Reset asserted mid-instruction SHALL abandon the instruction without done_pulse or counter update.
- REQ-036: The first handshake SHALL be possible at the first rising edge after reset deasserts.

Verification
- REQ-037: Scenario: instr=16'h3_0C5 (opcode 0011), fsm_done[0] pulsed 13 cycles after FSM_start -> FSM_start=0001 for 1 cycle at N+2, done_pulse 1 cycle, instr_count=1, opcode=0011.
- REQ-038: Scenario: opcode 1000, 1001 and 1010 back-to-back with prompt done -> FSM_start=0010, then 0100, then 1000; instr_count=3; no gaps beyond the REQ-022 latency.
- REQ-039: Scenario: opcode 1100 -> ERROR after DECODE, error=1, timeout=0, no FSM_start pulse; clear_error -> IDLE, instr_ready=1.
- REQ-040: Scenario: ALU op with no done, TIMEOUT_CYCLES=32 -> ERROR after 32 WAIT cycles, timeout=1; fsm_done[2] pulses during WAIT are ignored.
- REQ-041: Scenario: selected done coincident with the final timeout cycle -> COMPLETE, error=0; then 2^CNT_W retirements -> instr_count wraps to 0.
- REQ-042: Scenario: reset=0 asserted in WAIT -> outputs reset within the same cycle, instr_count=0, no done_pulse.
